// File: rtl/systolic_tile_scheduler.sv
// Steps the systolic array controller through a batch of output-stationary tiles.
// Define SCHED_PERF_CNT_EN to add the busy-cycle and ack-stall performance counters.
module systolic_tile_scheduler #(
    parameter int unsigned NUM_ROW              = 8,
    parameter int unsigned NUM_COL              = 8,
    parameter int unsigned LOG2_SRAM_BANK_DEPTH = 10,
    parameter int unsigned CTRL_WIDTH           = 4,
    parameter int unsigned TILE_CNT_WIDTH       = 8,
    parameter int unsigned DRAIN_TIMEOUT        = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [TILE_CNT_WIDTH-1:0]       i_num_tiles,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_k_len,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_base,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_base,
    input  logic                            i_valid_down_last,
    input  logic                            i_tile_ack,
    output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_end_addr,
    output logic [TILE_CNT_WIDTH-1:0]       o_tile_idx,
    output logic                            o_busy,
    output logic                            o_tile_done,
    output logic                            o_done,
    output logic                            o_err
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                     o_perf_busy_cycles,
    output logic [31:0]                     o_perf_ack_stall_cycles
`endif
);

    localparam int unsigned AW        = LOG2_SRAM_BANK_DEPTH;
    localparam int unsigned FLUSH_LEN = NUM_ROW + NUM_COL - 1;
    localparam int unsigned FLUSH_W   = $clog2(FLUSH_LEN + 1);
    localparam int unsigned CNT_W     = (AW > FLUSH_W) ? AW : FLUSH_W;
    localparam int unsigned DCNT_W    = $clog2(NUM_ROW + 1);
    localparam int unsigned TMR_W     = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE   = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] CTRL_STEADY = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] CTRL_DRAIN  = CTRL_WIDTH'(3);

    typedef enum logic [2:0] {StIdle, StSetup, StSteady, StFlush, StDrain, StWaitAck} state_e;

    state_e                    state_q;
    logic [AW-1:0]             k_len_q;
    logic [TILE_CNT_WIDTH-1:0] num_tiles_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [DCNT_W-1:0]         drain_cnt_q;
    logic [TMR_W-1:0]          drain_tmr_q;

    logic                      start_ok;
    logic [CNT_W-1:0]          cnt_nxt;
    logic [DCNT_W-1:0]         drain_cnt_nxt;
    logic [TMR_W-1:0]          drain_tmr_nxt;

    assign start_ok      = (state_q == StIdle) && i_start && (i_num_tiles != '0) && (i_k_len != '0);
    assign cnt_nxt       = cnt_q + CNT_W'(1);
    assign drain_cnt_nxt = drain_cnt_q + DCNT_W'(i_valid_down_last);
    assign drain_tmr_nxt = drain_tmr_q + TMR_W'(1);

    // Windows are loaded on the way into setup so they are valid during the setup cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= StIdle;
            k_len_q              <= '0;
            num_tiles_q          <= '0;
            cnt_q                <= '0;
            drain_cnt_q          <= '0;
            drain_tmr_q          <= '0;
            o_ctrl_state         <= CTRL_IDLE;
            o_top_rd_start_addr  <= '0;
            o_top_rd_end_addr    <= '0;
            o_left_rd_start_addr <= '0;
            o_left_rd_end_addr   <= '0;
            o_tile_idx           <= '0;
            o_busy               <= 1'b0;
            o_tile_done          <= 1'b0;
            o_done               <= 1'b0;
            o_err                <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        k_len_q              <= i_k_len;
                        num_tiles_q          <= i_num_tiles;
                        o_tile_idx           <= '0;
                        o_top_rd_start_addr  <= i_top_base;
                        o_top_rd_end_addr    <= i_top_base + i_k_len;
                        o_left_rd_start_addr <= i_left_base;
                        o_left_rd_end_addr   <= i_left_base + i_k_len;
                        o_busy               <= 1'b1;
                        state_q              <= StSetup;
                    end else if (i_start && i_num_tiles == '0) begin
                        o_done <= 1'b1;
                    end else if (i_start) begin
                        o_err <= 1'b1;
                    end
                end
                StSetup: begin
                    cnt_q        <= '0;
                    o_ctrl_state <= CTRL_STEADY;
                    state_q      <= StSteady;
                end
                StSteady: begin
                    if (cnt_nxt == CNT_W'(k_len_q)) begin
                        cnt_q   <= '0;
                        state_q <= StFlush;
                    end else begin
                        cnt_q <= cnt_nxt;
                    end
                end
                StFlush: begin
                    if (cnt_nxt == CNT_W'(FLUSH_LEN)) begin
                        cnt_q        <= '0;
                        drain_cnt_q  <= '0;
                        drain_tmr_q  <= '0;
                        o_ctrl_state <= CTRL_DRAIN;
                        state_q      <= StDrain;
                    end else begin
                        cnt_q <= cnt_nxt;
                    end
                end
                StDrain: begin
                    // A completed drain wins over a timeout landing on the same cycle.
                    if (drain_cnt_nxt == DCNT_W'(NUM_ROW)) begin
                        o_ctrl_state <= CTRL_IDLE;
                        o_tile_done  <= 1'b1;
                        state_q      <= StWaitAck;
                    end else if (drain_tmr_nxt == TMR_W'(DRAIN_TIMEOUT)) begin
                        o_ctrl_state <= CTRL_IDLE;
                        o_busy       <= 1'b0;
                        o_err        <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        drain_cnt_q <= drain_cnt_nxt;
                        drain_tmr_q <= drain_tmr_nxt;
                    end
                end
                StWaitAck: begin
                    if (i_tile_ack) begin
                        o_tile_done <= 1'b0;
                        if (o_tile_idx == num_tiles_q - TILE_CNT_WIDTH'(1)) begin
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            o_tile_idx          <= o_tile_idx + TILE_CNT_WIDTH'(1);
                            o_top_rd_start_addr <= o_top_rd_end_addr;
                            o_top_rd_end_addr   <= o_top_rd_end_addr + k_len_q;
                            state_q             <= StSetup;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            o_perf_busy_cycles      <= '0;
            o_perf_ack_stall_cycles <= '0;
        end else begin
            if (o_busy && o_perf_busy_cycles != '1) begin
                o_perf_busy_cycles <= o_perf_busy_cycles + 32'd1;
            end
            if (state_q == StWaitAck && o_perf_ack_stall_cycles != '1) begin
                o_perf_ack_stall_cycles <= o_perf_ack_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed and randomized batches checked cycle by cycle against a tile-timing model.
module tb_systolic_tile_scheduler;

    localparam int AW    = 10;
    localparam int NR    = 8;
    localparam int NC    = 8;
    localparam int FL    = NR + NC - 1;
    localparam int TO    = 256;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [7:0]    i_num_tiles = '0;
    logic [AW-1:0] i_k_len = '0;
    logic [AW-1:0] i_top_base = '0;
    logic [AW-1:0] i_left_base = '0;
    logic          i_valid_down_last = 1'b0;
    logic          i_tile_ack = 1'b0;
    logic [3:0]    o_ctrl_state;
    logic [AW-1:0] o_top_rd_start_addr, o_top_rd_end_addr;
    logic [AW-1:0] o_left_rd_start_addr, o_left_rd_end_addr;
    logic [7:0]    o_tile_idx;
    logic          o_busy, o_tile_done, o_done, o_err;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]   o_perf_busy_cycles, o_perf_ack_stall_cycles;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    systolic_tile_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_start              (i_start),
        .i_num_tiles          (i_num_tiles),
        .i_k_len              (i_k_len),
        .i_top_base           (i_top_base),
        .i_left_base          (i_left_base),
        .i_valid_down_last    (i_valid_down_last),
        .i_tile_ack           (i_tile_ack),
        .o_ctrl_state         (o_ctrl_state),
        .o_top_rd_start_addr  (o_top_rd_start_addr),
        .o_top_rd_end_addr    (o_top_rd_end_addr),
        .o_left_rd_start_addr (o_left_rd_start_addr),
        .o_left_rd_end_addr   (o_left_rd_end_addr),
        .o_tile_idx           (o_tile_idx),
        .o_busy               (o_busy),
        .o_tile_done          (o_tile_done),
        .o_done               (o_done),
`ifdef SCHED_PERF_CNT_EN
        .o_err                (o_err),
        .o_perf_busy_cycles   (o_perf_busy_cycles),
        .o_perf_ack_stall_cycles (o_perf_ack_stall_cycles)
`else
        .o_err                (o_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'(o_ctrl_state), 0);
        chk({tag, "_top_s"}, 32'(o_top_rd_start_addr), 0);
        chk({tag, "_top_e"}, 32'(o_top_rd_end_addr), 0);
        chk({tag, "_left_s"}, 32'(o_left_rd_start_addr), 0);
        chk({tag, "_left_e"}, 32'(o_left_rd_end_addr), 0);
        chk({tag, "_idx"}, 32'(o_tile_idx), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_tdone"}, 32'(o_tile_done), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_err"}, 32'(o_err), 0);
`ifdef SCHED_PERF_CNT_EN
        chk({tag, "_perf_busy"}, o_perf_busy_cycles, 0);
        chk({tag, "_perf_stall"}, o_perf_ack_stall_cycles, 0);
`endif
    endtask

    // vmode: 0 valid always high, 1 random valid, 2 valid never high.
    // ack_dly: extra wait-ack cycles before the host acks (0 = ack already high on entry).
    task automatic run_batch(input int n, input int k, input int tb, input int lb,
                             input int vmode, input int ack_dly, input int abort_tile);
        int  hits;
        int  d;
        int  busy_exp;
        logic v;
        busy_exp = 0;
        @(negedge clk);
        i_start     = 1'b1;
        i_num_tiles = 8'(n);
        i_k_len     = AW'(k);
        i_top_base  = AW'(tb);
        i_left_base = AW'(lb);
        step();
        i_start = 1'b0;
        for (int t = 0; t < n; t++) begin
            chk("setup_ctrl", 32'(o_ctrl_state), 0);
            chk("setup_busy", 32'(o_busy), 1);
            chk("setup_done", 32'(o_done), 0);
            chk("setup_tdone", 32'(o_tile_done), 0);
            chk("setup_idx", 32'(o_tile_idx), 32'(t));
            chk("top_start", 32'(o_top_rd_start_addr), 32'((tb + t * k) % DEPTH));
            chk("top_end", 32'(o_top_rd_end_addr), 32'((tb + (t + 1) * k) % DEPTH));
            chk("left_start", 32'(o_left_rd_start_addr), 32'(lb % DEPTH));
            chk("left_end", 32'(o_left_rd_end_addr), 32'((lb + k) % DEPTH));
            busy_exp += 1 + k + FL;
            for (int i = 0; i < k + FL; i++) begin
                // A stray start mid-batch must not disturb the running tile.
                i_start = (i == 0);
                i_k_len = (i == 0) ? '0 : AW'(k);
                step();
                i_start = 1'b0;
                chk("steady_ctrl", 32'(o_ctrl_state), 1);
                if (t == abort_tile && i == 1) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    chk_all_zero("abort");
                    return;
                end
            end
            hits = 0;
            d    = 0;
            while (hits < NR) begin
                step();
                chk("drain_ctrl", 32'(o_ctrl_state), 3);
                chk("drain_tdone", 32'(o_tile_done), 0);
                if (vmode == 0) v = 1'b1;
                else if (vmode == 2) v = 1'b0;
                else v = 1'($urandom_range(0, 1));
                i_valid_down_last = v;
                hits += int'(v);
                d++;
                if (hits < NR && d == TO) begin
                    step();
                    i_valid_down_last = 1'b0;
                    chk("timeout_err", 32'(o_err), 1);
                    chk("timeout_busy", 32'(o_busy), 0);
                    chk("timeout_ctrl", 32'(o_ctrl_state), 0);
                    chk("timeout_tdone", 32'(o_tile_done), 0);
                    step();
                    chk("timeout_err_pulse", 32'(o_err), 0);
                    chk("timeout_idle_ctrl", 32'(o_ctrl_state), 0);
                    return;
                end
            end
            busy_exp += d;
            if (ack_dly == 0) i_tile_ack = 1'b1;
            step();
            i_valid_down_last = 1'b0;
            chk("wait_ctrl", 32'(o_ctrl_state), 0);
            chk("wait_tdone", 32'(o_tile_done), 1);
            chk("wait_busy", 32'(o_busy), 1);
            for (int j = 1; j <= ack_dly; j++) begin
                step();
                chk("wait_hold_tdone", 32'(o_tile_done), 1);
                chk("wait_hold_ctrl", 32'(o_ctrl_state), 0);
                if (j == ack_dly) i_tile_ack = 1'b1;
            end
            busy_exp += ack_dly + 1;
            step();
            i_tile_ack = 1'b0;
            chk("ack_tdone", 32'(o_tile_done), 0);
            if (t == n - 1) begin
                chk("end_done", 32'(o_done), 1);
                chk("end_busy", 32'(o_busy), 0);
                chk("end_ctrl", 32'(o_ctrl_state), 0);
`ifdef SCHED_PERF_CNT_EN
                chk("perf_busy", o_perf_busy_cycles, 32'(busy_exp));
                chk("perf_stall", o_perf_ack_stall_cycles, 32'(n * (ack_dly + 1)));
`endif
                step();
                chk("end_done_pulse", 32'(o_done), 0);
                chk("end_idle_ctrl", 32'(o_ctrl_state), 0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Single tile, prompt drain, ack 2 cycles after tile_done.
        run_batch(1, 8, 0, 0, 0, 2, -1);
        // Three tiles walking the top window.
        run_batch(3, 4, 10, 0, 0, 1, -1);
        // Top window wraps past the end of the bank.
        run_batch(1, 8, 1020, 0, 0, 0, -1);

        // Zero reduction length.
        @(negedge clk);
        i_start = 1'b1; i_num_tiles = 8'd2; i_k_len = '0;
        step();
        i_start = 1'b0;
        chk("klen0_err", 32'(o_err), 1);
        chk("klen0_busy", 32'(o_busy), 0);
        chk("klen0_done", 32'(o_done), 0);
        step();
        chk("klen0_err_pulse", 32'(o_err), 0);
        chk("klen0_busy_after", 32'(o_busy), 0);

        // Empty batch.
        @(negedge clk);
        i_start = 1'b1; i_num_tiles = 8'd0; i_k_len = AW'(5);
        step();
        i_start = 1'b0;
        chk("ntiles0_done", 32'(o_done), 1);
        chk("ntiles0_busy", 32'(o_busy), 0);
        chk("ntiles0_err", 32'(o_err), 0);
        step();
        chk("ntiles0_no_setup_busy", 32'(o_busy), 0);
        chk("ntiles0_done_pulse", 32'(o_done), 0);

        // Drain never completes.
        run_batch(1, 3, 100, 50, 2, 0, -1);

        // Reset during steady of tile 1, then a clean batch.
        run_batch(3, 6, 5, 7, 0, 1, 1);
        run_batch(2, 5, 300, 900, 0, 0, -1);

        // Wait-ack lasting 5 cycles.
        run_batch(1, 8, 0, 0, 0, 4, -1);

        for (int r = 0; r < 8; r++) begin
            run_batch($urandom_range(1, 3), $urandom_range(1, 20), $urandom_range(0, DEPTH - 1),
                      $urandom_range(0, DEPTH - 1), 1, $urandom_range(0, 3), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
